// File: rtl/semaforo_pkg.sv
// Shared definitions for the four-approach traffic light controller:
// phase encodings, approach indices and small arithmetic helpers.
package semaforo_pkg;

    typedef enum logic [1:0] {
        PH_ALL_RED = 2'd0,
        PH_GREEN   = 2'd1,
        PH_YELLOW  = 2'd2
    } phase_t;

    localparam logic [1:0] APP_A = 2'd0;
    localparam logic [1:0] APP_B = 2'd1;
    localparam logic [1:0] APP_C = 2'd2;
    localparam logic [1:0] APP_D = 2'd3;

    // One-hot lamp/request mask for an approach index.
    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

    // 8-bit increment that sticks at 255 instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/semaforo_fsm_rr_pick4.sv
// Round-robin request picker: returns the first set bit of pending
// searching upward from ptr+1 (modulo 4), wrapping back to ptr itself last.
module rr_pick4
    import semaforo_pkg::*;
(
    input  logic [3:0] pending,
    input  logic [1:0] ptr,
    output logic [1:0] grant,
    output logic       any
);

    logic [1:0] idx;

    // Walk the candidates from the farthest (ptr+4 == ptr) to the nearest
    // (ptr+1) so the nearest set request is the one left standing.
    always_comb begin
        grant = ptr;
        any   = 1'b0;
        idx   = ptr;
        for (int k = 4; k >= 1; k--) begin
            idx = ptr + 2'(k);
            if (pending[idx]) begin
                grant = idx;
                any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/semaforo_fsm.sv
// Four-approach traffic light controller. Serves one approach at a time in
// round-robin order: ALL_RED gap -> GREEN (minimum time, extended while no one
// else waits) -> YELLOW (exact time) -> ALL_RED. All outputs are registered
// and lamps change on the same edge as phase.
module semaforo_fsm
    import semaforo_pkg::*;
#(
    parameter int unsigned GREEN_TIME  = 8,
    parameter int unsigned YELLOW_TIME = 3,
    parameter int unsigned ALLRED_TIME = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       A,
    input  logic       B,
    input  logic       C,
    input  logic       D,
    output logic       FA,
    output logic       FB,
    output logic       FC,
    output logic       FD,
    output logic       YA,
    output logic       YB,
    output logic       YC,
    output logic       YD,
    output logic [1:0] phase,
    output logic [1:0] cur
);

    // Timer holds "cycles already spent in this state", so the last cycle of
    // an N-cycle interval is the one where the timer reads N-1.
    localparam logic [7:0] GREEN_LAST  = 8'(GREEN_TIME - 1);
    localparam logic [7:0] YELLOW_LAST = 8'(YELLOW_TIME - 1);
    localparam logic [7:0] ALLRED_LAST = 8'(ALLRED_TIME - 1);

    phase_t     state;
    logic [7:0] timer;
    logic [1:0] ptr;
    logic [3:0] pending;
    logic [3:0] sensors;
    logic [3:0] set_mask;
    logic [3:0] other_pending;
    logic [3:0] green_lamps;
    logic [3:0] yellow_lamps;
    logic [1:0] grant;
    logic       any_pending;

    rr_pick4 u_pick (
        .pending (pending),
        .ptr     (ptr),
        .grant   (grant),
        .any     (any_pending)
    );

    // Requests raised this cycle; the approach currently green cannot re-queue itself.
    always_comb begin
        sensors  = {D, C, B, A};
        set_mask = sensors;
        if (state == PH_GREEN) begin
            set_mask = sensors & ~onehot4(cur);
        end
        other_pending = pending & ~onehot4(cur);
    end

    // Phase FSM with its timer, round-robin pointer, request latch and lamp registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= PH_ALL_RED;
            timer        <= '0;
            ptr          <= APP_D;
            pending      <= '0;
            cur          <= APP_A;
            green_lamps  <= '0;
            yellow_lamps <= '0;
        end else begin
            pending <= pending | set_mask;
            timer   <= sat_inc8(timer);
            case (state)
                PH_ALL_RED: begin
                    if (timer >= ALLRED_LAST && any_pending) begin
                        state        <= PH_GREEN;
                        cur          <= grant;
                        timer        <= '0;
                        // The served request is consumed; clear wins over a same-cycle set.
                        pending      <= (pending | set_mask) & ~onehot4(grant);
                        green_lamps  <= onehot4(grant);
                        yellow_lamps <= '0;
                    end
                end
                PH_GREEN: begin
                    if (timer >= GREEN_LAST && (|other_pending)) begin
                        state        <= PH_YELLOW;
                        timer        <= '0;
                        green_lamps  <= '0;
                        yellow_lamps <= onehot4(cur);
                    end
                end
                PH_YELLOW: begin
                    if (timer == YELLOW_LAST) begin
                        state        <= PH_ALL_RED;
                        timer        <= '0;
                        ptr          <= cur;
                        green_lamps  <= '0;
                        yellow_lamps <= '0;
                    end
                end
                default: begin
                    state        <= PH_ALL_RED;
                    timer        <= '0;
                    green_lamps  <= '0;
                    yellow_lamps <= '0;
                end
            endcase
        end
    end

    assign phase = state;
    assign FA    = green_lamps[0];
    assign FB    = green_lamps[1];
    assign FC    = green_lamps[2];
    assign FD    = green_lamps[3];
    assign YA    = yellow_lamps[0];
    assign YB    = yellow_lamps[1];
    assign YC    = yellow_lamps[2];
    assign YD    = yellow_lamps[3];

endmodule

// File: tb/tb_semaforo_fsm.sv
// Directed bench for semaforo_fsm with a cycle model feeding an expected queue.
module tb_semaforo_fsm;
    import semaforo_pkg::*;

    localparam int GT = 8;
    localparam int YT = 3;
    localparam int AT = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       A, B, C, D;
    logic       FA, FB, FC, FD;
    logic       YA, YB, YC, YD;
    logic [1:0] phase;
    logic [1:0] cur;

    int checks = 0;
    int errors = 0;

    // Packed expectation: {pending[3:0], phase[1:0], cur[1:0], F[3:0], Y[3:0]}
    logic [15:0] exp_q[$];
    logic [1:0]  grant_log[$];
    logic [1:0]  want[$];

    phase_t     m_phase;
    logic [1:0] m_cur;
    logic [1:0] m_ptr;
    logic [3:0] m_pend;
    int         m_cnt;

    logic [1:0] prev_ph;
    int         run_len;

    semaforo_fsm #(
        .GREEN_TIME  (GT),
        .YELLOW_TIME (YT),
        .ALLRED_TIME (AT)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .A     (A),
        .B     (B),
        .C     (C),
        .D     (D),
        .FA    (FA),
        .FB    (FB),
        .FC    (FC),
        .FD    (FD),
        .YA    (YA),
        .YB    (YB),
        .YC    (YC),
        .YD    (YD),
        .phase (phase),
        .cur   (cur)
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] observe();
        return {dut.pending, phase, cur, FD, FC, FB, FA, YD, YC, YB, YA};
    endfunction

    task automatic model_reset();
        m_phase = PH_ALL_RED;
        m_cur   = APP_A;
        m_ptr   = APP_D;
        m_pend  = 4'b0;
        m_cnt   = 0;
    endtask

    function automatic logic [15:0] model_pack();
        logic [3:0] g;
        logic [3:0] y;
        g = 4'b0;
        y = 4'b0;
        if (m_phase == PH_GREEN)  g[m_cur] = 1'b1;
        if (m_phase == PH_YELLOW) y[m_cur] = 1'b1;
        return {m_pend, m_phase, m_cur, g, y};
    endfunction

    // Advance the model by one clock edge given the sensors seen before it.
    task automatic model_step(input logic [3:0] sens);
        logic [3:0] np;
        logic [3:0] others;
        logic [1:0] idx;
        bit         found;
        if (rst) begin
            model_reset();
            return;
        end
        np = m_pend | sens;
        if (m_phase == PH_GREEN) np[m_cur] = m_pend[m_cur];
        others = m_pend;
        others[m_cur] = 1'b0;
        found = 1'b0;
        idx = m_cur;
        case (m_phase)
            PH_ALL_RED: begin
                if (m_cnt >= AT - 1 && m_pend != 4'b0) begin
                    for (int k = 1; k <= 4; k++) begin
                        if (!found && m_pend[(int'(m_ptr) + k) % 4]) begin
                            found = 1'b1;
                            idx = 2'((int'(m_ptr) + k) % 4);
                        end
                    end
                end
                if (found) begin
                    m_phase = PH_GREEN;
                    m_cur   = idx;
                    np[idx] = 1'b0;
                    m_cnt   = 0;
                end else begin
                    m_cnt++;
                end
            end
            PH_GREEN: begin
                if (m_cnt >= GT - 1 && others != 4'b0) begin
                    m_phase = PH_YELLOW;
                    m_cnt   = 0;
                end else begin
                    m_cnt++;
                end
            end
            default: begin
                if (m_cnt == YT - 1) begin
                    m_phase = PH_ALL_RED;
                    m_ptr   = m_cur;
                    m_cnt   = 0;
                end else begin
                    m_cnt++;
                end
            end
        endcase
        m_pend = np;
    endtask

    task automatic compare_now();
        logic [15:0] e;
        logic [15:0] o;
        logic [3:0]  f;
        logic [3:0]  y;
        logic        ok;
        e = exp_q.pop_front();
        o = observe();
        check("phase",   16'(o[11:10]), 16'(e[11:10]));
        check("lamps",   16'(o[7:0]),   16'(e[7:0]));
        check("pending", 16'(o[15:12]), 16'(e[15:12]));
        if (e[11:10] != PH_ALL_RED) check("cur", 16'(o[9:8]), 16'(e[9:8]));
        f  = o[7:4];
        y  = o[3:0];
        ok = ($countones(f | y) <= 1) && ((f & y) == 4'b0);
        check("exclusive", {15'b0, ok}, 16'd1);
    endtask

    // Interval lengths measured purely from observed outputs.
    task automatic track();
        if (phase != prev_ph) begin
            case (prev_ph)
                PH_ALL_RED: check("allred_gap", {15'b0, run_len >= AT}, 16'd1);
                PH_GREEN:   check("green_min",  {15'b0, run_len >= GT}, 16'd1);
                PH_YELLOW:  check("yellow_len", 16'(run_len), 16'(YT));
                default: ;
            endcase
            if (phase == PH_GREEN) grant_log.push_back(cur);
            run_len = 1;
        end else begin
            run_len++;
        end
        prev_ph = phase;
    endtask

    // Driver: apply sensors for one cycle, queue the expectation, compare after the edge.
    task automatic cycle(input logic [3:0] sens);
        {D, C, B, A} = sens;
        model_step(sens);
        exp_q.push_back(model_pack());
        @(posedge clk);
        #1;
        compare_now();
        track();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        {D, C, B, A} = 4'b0;
        prev_ph = PH_ALL_RED;
        run_len = 0;
        grant_log.delete();
        model_reset();
        #1;
        exp_q.push_back(model_pack());
        compare_now();
        check("rst_cur",   16'(cur),       16'(APP_A));
        check("rst_ptr",   16'(dut.ptr),   16'(APP_D));
        check("rst_timer", 16'(dut.timer), 16'd0);
        cycle(4'b0);
        cycle(4'b0);
        rst = 1'b0;
        run_len = 1;
    endtask

    task automatic check_order(input string tag);
        check({tag, "_count"}, {15'b0, grant_log.size() >= want.size()}, 16'd1);
        for (int i = 0; i < want.size(); i++) begin
            if (i < grant_log.size()) check(tag, 16'(grant_log[i]), 16'(want[i]));
        end
    endtask

    initial begin
        int waited;
        rst = 1'b1;
        {D, C, B, A} = 4'b0;
        #2;

        // No requests: everything stays red
        do_reset();
        repeat (100) cycle(4'b0000);
        check("idle_phase", 16'(phase), 16'(PH_ALL_RED));
        check("idle_log", 16'(grant_log.size()), 16'd0);

        // One-cycle pulse on B, green extended while nobody else waits
        cycle(4'b0010);
        repeat (40) cycle(4'b0000);
        check("b_held_fb", 16'(FB), 16'd1);
        check("b_held_cur", 16'(cur), 16'(APP_B));
        want = '{APP_B};
        check_order("b_order");

        // A and C pulsed together after reset
        do_reset();
        cycle(4'b0101);
        repeat (45) cycle(4'b0000);
        want = '{APP_A, APP_C};
        check_order("ac_order");

        // All approaches held high
        do_reset();
        repeat (75) cycle(4'b1111);
        want = '{APP_A, APP_B, APP_C, APP_D, APP_A};
        check_order("rr_order");

        // A held during its own green, then B requested
        do_reset();
        repeat (30) cycle(4'b0001);
        check("a_self_pend", 16'(dut.pending[0]), 16'd0);
        check("a_green_fa", 16'(FA), 16'd1);
        cycle(4'b0010);
        repeat (25) cycle(4'b0000);
        want = '{APP_A, APP_B};
        check_order("ab_order");

        // Reset in the 5th cycle of C's green
        do_reset();
        cycle(4'b0100);
        waited = 0;
        while (!(phase == PH_GREEN && cur == APP_C) && waited < 20) begin
            cycle(4'b0000);
            waited++;
        end
        check("fc_reached", {15'b0, (phase == PH_GREEN && cur == APP_C)}, 16'd1);
        repeat (4) cycle(4'b0000);
        do_reset();
        repeat (12) cycle(4'b0100);
        want = '{APP_C};
        check_order("post_rst_order");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
